ex_div: RTL and testbench
=========================

# ex_div

Execute stage of the five-stage MIPS pipeline. It consumes the decoded operation and operands from the ID/EX latch and produces the write-back triple (`wdata_o`/`waddr_o`/`wreg_o`). That triple feeds the EX/MEM latch and the ID-stage forwarding inputs (`ex_wdata_i`/`ex_waddr_i`/`ex_wreg_i`). Logic, shift and LUI operations complete combinationally. DIV/DIVU run on an internal 32-step iterative divider that stalls the pipeline through `stallreq_o` and writes HI/LO on completion.

## Interface
- `DIV_STEPS`, 32: divider iterations; fixed equal to data width.
- Clock and reset: one clock; reset is asynchronous and active-high (`clk`, `rst`).
- `clk`  in  1  pipeline clock
- `rst`  in  1  async reset, active-high (`RstEna`)
- `aluop_i`  in  `AluOpBus`  operation from ID/EX
- `alusel_i`  in  `AluSelBus`  result class from ID/EX
- `reg1_i`  in  32  source operand 1 (rs, or shamt/imm)
- `reg2_i`  in  32  source operand 2 (rt or imm)
- `waddr_i`  in  5  destination register
- `wreg_i`  in  1  destination write enable
- `wdata_o`  out  32  result
- `waddr_o`  out  5  destination register
- `wreg_o`  out  1  destination write enable
- `hi_o`  out  32  HI write data
- `lo_o`  out  32  LO write data
- `whilo_o`  out  1  HI/LO write enable (one-cycle pulse)
- `stallreq_o`  out  1  stall request to pipeline control

## Operation
- Combinational result selection by `aluop_i`:
  - AND/OR/XOR/NOR: `reg1_i` op `reg2_i`.
  - LUI_OP: `reg2_i` (ID supplies `{imm,16'h0}`).
  - SLL_OP: `reg2_i << reg1_i[4:0]`.
  - SRL_OP: logical right shift of `reg2_i` by `reg1_i[4:0]`.
  - SRA_OP: arithmetic right shift of `reg2_i` by `reg1_i[4:0]`. Applies for both `EXE_RES_SHIFT` and `EXE_RES_ARITH` alusel.
  - Any other aluop: 0.
- `alusel_i == EXE_RES_NOP` forces `wdata_o = 0`.
- `waddr_o = waddr_i`. `wreg_o = wreg_i`, except forced 0 for DIV_OP/DIVU_OP.
- Divider FSM states:
  - IDLE: a div op starts the divider. Divisor ≠ 0 → BUSY with count = 0. Divisor = 0 → DONE.
  - BUSY: one restoring shift-subtract step per cycle on a 65-bit {remainder, quotient} register. After step 31 → DONE.
  - DONE: holds the result one cycle → IDLE.
- Signed DIV: operate on magnitudes. Quotient negative iff the sign bits differ. Remainder takes the sign of the dividend. Signs are captured at start.
- Divide by zero: `lo_o = 32'hFFFF_FFFF`, `hi_o = reg1_i` (dividend, unmodified).
- Overflow 0x8000_0000 / -1 (signed): `lo_o = 32'h8000_0000`, `hi_o = 0`. This falls out of the magnitude method with two's-complement fix-up.
- Operands are latched at start. Changes on `reg1_i`/`reg2_i` during BUSY are ignored.
- `hi_o`/`lo_o` hold the last result and change only on entry to DONE.

## Timing
- Reset values:
  - FSM = IDLE, count = 0.
  - `hi_o = lo_o = 0`.
  - `whilo_o = 0`, `stallreq_o = 0`.
  - `wdata_o`/`waddr_o`/`wreg_o` follow the combinational inputs. With the upstream latch in reset, all are 0.
- Logic/shift/LUI: zero-cycle latency, valid in the same cycle as the inputs.
- `stallreq_o = (IDLE & div op) | BUSY`. It is combinational, so it rises in the issue cycle.
- Normal div: issue cycle T, BUSY T+1..T+32, DONE T+33.
  - `whilo_o = 1` and HI/LO valid only in T+33.
  - `stallreq_o = 0` in T+33, so the instruction retires at the end of T+33.
  - Total occupancy is 34 cycles.
- Div by zero: issue T (stall), DONE T+1 (`whilo_o = 1`).
- In DONE, the div op still present on `aluop_i` does not restart the divider. DONE always returns to IDLE.
- Back-to-back divs: the second starts in the cycle after DONE.
- Async `rst` mid-BUSY:
  - FSM → IDLE and `stallreq_o` → 0 immediately.
  - No `whilo_o` pulse. HI/LO are cleared.
- A non-div aluop appearing while BUSY (illegal under stall) does not abort the divider.

## Test plan
- ORI/OR path: `aluop = OR_OP`, `alusel = LOGIC`, `reg1 = 0x0000_1100`, `reg2 = 0x0000_0020`, `waddr = 5`, `wreg = 1` → same cycle `wdata_o = 0x0000_1120`, `waddr_o = 5`, `wreg_o = 1`.
- Shifts with `reg2 = 0x8000_0010`, `reg1 = 4`:
  - SLL → `0x0000_0100`.
  - SRL → `0x0800_0001`.
  - SRA with `alusel = ARITH` → `0xF800_0001`.
  - `alusel = NOP` → 0.
- DIVU `0x0000_0064 / 0x0000_0007`:
  - `stallreq_o` high for exactly 33 cycles.
  - Then one cycle with `whilo_o = 1`, `lo_o = 14`, `hi_o = 2`.
  - `wreg_o = 0` throughout.
- DIV `-7 (0xFFFF_FFF9) / 2` → `lo_o = 0xFFFF_FFFD`, `hi_o = 0xFFFF_FFFF`. Plus signed overflow `0x8000_0000 / 0xFFFF_FFFF` → `lo_o = 0x8000_0000`, `hi_o = 0`.
- DIV by zero with `reg1 = 0x1234_5678` → `stallreq_o` for 1 cycle, next cycle `whilo_o = 1`, `lo_o = 0xFFFF_FFFF`, `hi_o = 0x1234_5678`.
- Assert `rst` at BUSY step 10:
  - `stallreq_o` drops asynchronously; `hi_o = lo_o = 0`; no `whilo_o` pulse.
  - After release, a fresh DIVU `9/3` completes normally: `lo_o = 3`, `hi_o = 0`.

Source files
------------

// File: rtl/ex_div_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ex_div_if
// Brief    : ID/EX operand bundle into the execute stage and its write-back,
//            HI/LO and stall outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface ex_div_if;
    logic [7:0]  aluop_i;
    logic [2:0]  alusel_i;
    logic [31:0] reg1_i;
    logic [31:0] reg2_i;
    logic [4:0]  waddr_i;
    logic        wreg_i;
    logic [31:0] wdata_o;
    logic [4:0]  waddr_o;
    logic        wreg_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        whilo_o;
    logic        stallreq_o;

    // master is the ID/EX side feeding the stage; slave is the execute stage
    modport master (
        output aluop_i, alusel_i, reg1_i, reg2_i, waddr_i, wreg_i,
        input  wdata_o, waddr_o, wreg_o, hi_o, lo_o, whilo_o, stallreq_o
    );
    modport slave (
        input  aluop_i, alusel_i, reg1_i, reg2_i, waddr_i, wreg_i,
        output wdata_o, waddr_o, wreg_o, hi_o, lo_o, whilo_o, stallreq_o
    );
endinterface
`default_nettype wire

// File: rtl/ex_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ex_div
// Brief    : MIPS execute stage: logic/shift/LUI results plus an iterative
//            restoring divider for DIV/DIVU that stalls the pipeline.
// Revision : 1.0 - initial release
// ============================================================================
module ex_div #(
    parameter int DIV_STEPS = 32
) (
    input  wire logic clk,
    input  wire logic rst,
    ex_div_if.slave   bus
);
    localparam logic [7:0] c_op_and  = 8'h24;
    localparam logic [7:0] c_op_or   = 8'h25;
    localparam logic [7:0] c_op_xor  = 8'h26;
    localparam logic [7:0] c_op_nor  = 8'h27;
    localparam logic [7:0] c_op_lui  = 8'h0F;
    localparam logic [7:0] c_op_sll  = 8'h7C;
    localparam logic [7:0] c_op_srl  = 8'h02;
    localparam logic [7:0] c_op_sra  = 8'h03;
    localparam logic [7:0] c_op_div  = 8'h1A;
    localparam logic [7:0] c_op_divu = 8'h1B;
    localparam logic [2:0] c_sel_nop = 3'b000;

    localparam int                  c_cnt_w = $clog2(DIV_STEPS);
    localparam logic [c_cnt_w-1:0]  c_last  = c_cnt_w'(DIV_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [c_cnt_w-1:0]  r_count;
    logic [64:0]         r_rq;
    logic [31:0]         r_divisor;
    logic                r_q_neg;
    logic                r_r_neg;
    logic [31:0]         r_hi;
    logic [31:0]         r_lo;

    logic        w_is_div;
    logic        w_signed;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [4:0]  w_shamt;
    logic [31:0] w_result;
    logic [64:0] w_shifted;
    logic [33:0] w_diff;
    logic [64:0] w_rq_step;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_lo_fix;
    logic [31:0] w_hi_fix;

    // ---------------- combinational result path ----------------
    assign w_shamt = bus.reg1_i[4:0];

    always_comb begin
        w_result = 32'h0;
        case (bus.aluop_i)
            c_op_and: w_result = bus.reg1_i & bus.reg2_i;
            c_op_or:  w_result = bus.reg1_i | bus.reg2_i;
            c_op_xor: w_result = bus.reg1_i ^ bus.reg2_i;
            c_op_nor: w_result = ~(bus.reg1_i | bus.reg2_i);
            c_op_lui: w_result = bus.reg2_i;
            c_op_sll: w_result = bus.reg2_i << w_shamt;
            c_op_srl: w_result = bus.reg2_i >> w_shamt;
            c_op_sra: w_result = $unsigned($signed(bus.reg2_i) >>> w_shamt);
            default:  w_result = 32'h0;
        endcase
    end

    assign w_is_div    = (bus.aluop_i == c_op_div) || (bus.aluop_i == c_op_divu);
    assign bus.wdata_o = (bus.alusel_i == c_sel_nop) ? 32'h0 : w_result;
    assign bus.waddr_o = bus.waddr_i;
    assign bus.wreg_o  = bus.wreg_i & ~w_is_div;

    // ---------------- divider operand preparation ----------------
    // Signed division runs on magnitudes; signs are fixed up on completion.
    assign w_signed = (bus.aluop_i == c_op_div);
    assign w_a_neg  = w_signed & bus.reg1_i[31];
    assign w_b_neg  = w_signed & bus.reg2_i[31];
    assign w_a_mag  = w_a_neg ? (~bus.reg1_i + 32'd1) : bus.reg1_i;
    assign w_b_mag  = w_b_neg ? (~bus.reg2_i + 32'd1) : bus.reg2_i;

    // One restoring step: the partial remainder stays below the divisor, so
    // the shifted value never exceeds 33 bits.
    assign w_shifted = r_rq << 1;
    assign w_diff    = {1'b0, w_shifted[64:32]} - {2'b00, r_divisor};
    assign w_rq_step = w_diff[33] ? w_shifted
                                  : {w_diff[32:0], w_shifted[31:1], 1'b1};
    assign w_q_mag   = w_rq_step[31:0];
    assign w_r_mag   = w_rq_step[63:32];
    assign w_lo_fix  = r_q_neg ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_hi_fix  = r_r_neg ? (~w_r_mag + 32'd1) : w_r_mag;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_is_div) begin
                    w_state_next = (bus.reg2_i == 32'h0) ? ST_DONE : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_count == c_last) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Gating with rst drops the stall the instant reset asserts, even if the
    // upstream latch still presents a divide.
    assign bus.stallreq_o = ~rst & (((r_state == ST_IDLE) & w_is_div) |
                                    (r_state == ST_BUSY));
    assign bus.whilo_o    = (r_state == ST_DONE);
    assign bus.hi_o       = r_hi;
    assign bus.lo_o       = r_lo;

    // ---------------- divider datapath ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_rq      <= '0;
            r_divisor <= '0;
            r_q_neg   <= 1'b0;
            r_r_neg   <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_is_div) begin
                        if (bus.reg2_i == 32'h0) begin
                            r_hi <= bus.reg1_i;
                            r_lo <= 32'hFFFF_FFFF;
                        end else begin
                            r_rq      <= {33'h0, w_a_mag};
                            r_divisor <= w_b_mag;
                            r_q_neg   <= w_a_neg ^ w_b_neg;
                            r_r_neg   <= w_a_neg;
                            r_count   <= '0;
                        end
                    end
                end
                ST_BUSY: begin
                    r_rq    <= w_rq_step;
                    r_count <= r_count + 1'b1;
                    if (r_count == c_last) begin
                        r_lo <= w_lo_fix;
                        r_hi <= w_hi_fix;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ex_div.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ex_div
// Brief    : Self-checking bench for ex_div against an arithmetic reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ex_div;
    localparam logic [7:0] c_op_and   = 8'h24;
    localparam logic [7:0] c_op_or    = 8'h25;
    localparam logic [7:0] c_op_xor   = 8'h26;
    localparam logic [7:0] c_op_nor   = 8'h27;
    localparam logic [7:0] c_op_lui   = 8'h0F;
    localparam logic [7:0] c_op_sll   = 8'h7C;
    localparam logic [7:0] c_op_srl   = 8'h02;
    localparam logic [7:0] c_op_sra   = 8'h03;
    localparam logic [7:0] c_op_div   = 8'h1A;
    localparam logic [7:0] c_op_divu  = 8'h1B;
    localparam logic [7:0] c_op_other = 8'h20;
    localparam logic [2:0] c_sel_nop   = 3'b000;
    localparam logic [2:0] c_sel_logic = 3'b001;
    localparam logic [2:0] c_sel_shift = 3'b010;
    localparam logic [2:0] c_sel_arith = 3'b100;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_lo = 32'h0;
    logic [31:0] last_hi = 32'h0;

    always #5 clk = ~clk;

    ex_div_if bus ();
    ex_div #(.DIV_STEPS(32)) dut (.clk(clk), .rst(rst), .bus(bus));

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_alu(input logic [7:0] op, input logic [2:0] sel,
                                            input logic [31:0] a, input logic [31:0] b);
        longint v;
        longint d;
        longint q;
        int     sh;
        sh = int'(a[4:0]);
        d  = longint'(1) << sh;
        if (sel == c_sel_nop) return 32'h0;
        case (op)
            c_op_and: return a & b;
            c_op_or:  return a | b;
            c_op_xor: return a ^ b;
            c_op_nor: return ~(a | b);
            c_op_lui: return b;
            c_op_sll: begin v = longint'(b) * d; return v[31:0]; end
            c_op_srl: begin v = longint'(b) / d; return v[31:0]; end
            c_op_sra: begin
                v = longint'($signed(b));
                q = v / d;
                if (v < 0 && (v % d) != 0) q = q - 1;
                return q[31:0];
            end
            default:  return 32'h0;
        endcase
    endfunction

    task automatic ref_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] lo, output logic [31:0] hi);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'h0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (op == c_op_divu) begin
            lo = a / b;
            hi = a % b;
        end else begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa - q * sb;
            lo = q[31:0];
            hi = r[31:0];
        end
    endtask

    task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wa, input logic we);
        bus.aluop_i  = op;
        bus.alusel_i = sel;
        bus.reg1_i   = a;
        bus.reg2_i   = b;
        bus.waddr_i  = wa;
        bus.wreg_i   = we;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        drive(8'h0, 3'h0, 32'h0, 32'h0, 5'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.hi_o !== 32'h0) begin errors++; $display("FAIL reset_hi got %h exp 0", bus.hi_o); end
        checks++; if (bus.lo_o !== 32'h0) begin errors++; $display("FAIL reset_lo got %h exp 0", bus.lo_o); end
        checks++; if (bus.whilo_o !== 1'b0) begin errors++; $display("FAIL reset_whilo got %b exp 0", bus.whilo_o); end
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", bus.stallreq_o); end
        checks++; if ({bus.wdata_o, bus.waddr_o, bus.wreg_o} !== 38'h0) begin
            errors++; $display("FAIL reset_wb got %h/%h/%b exp 0", bus.wdata_o, bus.waddr_o, bus.wreg_o);
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic check_alu(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] wa, input logic we,
                             input logic [31:0] exp, input string tag);
        @(posedge clk); #1;
        drive(op, sel, a, b, wa, we);
        @(negedge clk);
        checks++; if (bus.wdata_o !== exp) begin
            errors++; $display("FAIL %s wdata got %h exp %h (op %h a %h b %h)", tag, bus.wdata_o, exp, op, a, b);
        end
        checks++; if (bus.waddr_o !== wa || bus.wreg_o !== we) begin
            errors++; $display("FAIL %s wb got %h/%b exp %h/%b", tag, bus.waddr_o, bus.wreg_o, wa, we);
        end
        checks++; if (bus.stallreq_o !== 1'b0) begin
            errors++; $display("FAIL %s stall got %b exp 0", tag, bus.stallreq_o);
        end
    endtask

    task automatic test_logic();
        logic [7:0] ops [9] = '{c_op_and, c_op_or, c_op_xor, c_op_nor, c_op_lui,
                                c_op_sll, c_op_srl, c_op_sra, c_op_other};
        logic [2:0] sels [4] = '{c_sel_logic, c_sel_shift, c_sel_arith, c_sel_nop};
        logic [7:0]  op;
        logic [2:0]  sel;
        logic [31:0] a;
        logic [31:0] b;
        check_alu(c_op_or, c_sel_logic, 32'h0000_1100, 32'h0000_0020, 5'd5, 1'b1, 32'h0000_1120, "ori");
        check_alu(c_op_sll, c_sel_shift, 32'd4, 32'h8000_0010, 5'd3, 1'b1, 32'h0000_0100, "sll");
        check_alu(c_op_srl, c_sel_shift, 32'd4, 32'h8000_0010, 5'd3, 1'b1, 32'h0800_0001, "srl");
        check_alu(c_op_sra, c_sel_arith, 32'd4, 32'h8000_0010, 5'd3, 1'b1, 32'hF800_0001, "sra");
        check_alu(c_op_sra, c_sel_nop, 32'd4, 32'h8000_0010, 5'd3, 1'b1, 32'h0, "nop");
        for (int i = 0; i < 30; i++) begin
            op  = ops[$urandom_range(0, 8)];
            sel = sels[$urandom_range(0, 3)];
            a   = $urandom;
            b   = $urandom;
            check_alu(op, sel, a, b, 5'($urandom), 1'($urandom), ref_alu(op, sel, a, b), "alu_rand");
        end
    endtask

    // Leaves the divide op on the bus after DONE so a following call is back-to-back.
    task automatic run_div(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input string tag);
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
        int  n = 0;
        int  exp_n;
        bit  wreg_seen = 0;
        bit  whilo_early = 0;
        ref_div(op, a, b, exp_lo, exp_hi);
        exp_n = (b == 32'h0) ? 1 : 33;
        @(posedge clk); #1;
        drive(op, c_sel_arith, a, b, 5'($urandom_range(1, 31)), 1'b1);
        @(negedge clk);
        while (bus.stallreq_o === 1'b1 && n < 100) begin
            n++;
            if (bus.wreg_o !== 1'b0) wreg_seen = 1;
            if (bus.whilo_o !== 1'b0) whilo_early = 1;
            if (n >= 2) begin
                bus.reg1_i = $urandom;
                bus.reg2_i = $urandom;
            end
            @(negedge clk);
        end
        checks++; if (n != exp_n) begin errors++; $display("FAIL %s stall_cycles got %0d exp %0d", tag, n, exp_n); end
        checks++; if (bus.whilo_o !== 1'b1 || whilo_early) begin
            errors++; $display("FAIL %s whilo got %b early %0d exp 1 early 0", tag, bus.whilo_o, whilo_early);
        end
        checks++; if (bus.lo_o !== exp_lo || bus.hi_o !== exp_hi) begin
            errors++; $display("FAIL %s hilo got %h/%h exp %h/%h (a %h b %h)", tag, bus.hi_o, bus.lo_o, exp_hi, exp_lo, a, b);
        end
        checks++; if (wreg_seen || bus.wreg_o !== 1'b0) begin
            errors++; $display("FAIL %s wreg_o got 1 exp 0", tag);
        end
        last_lo = exp_lo;
        last_hi = exp_hi;
    endtask

    task automatic idle_check(input string tag);
        @(posedge clk); #1;
        drive(c_op_other, c_sel_nop, 32'h0, 32'h0, 5'h0, 1'b0);
        @(negedge clk);
        checks++; if (bus.whilo_o !== 1'b0 || bus.stallreq_o !== 1'b0) begin
            errors++; $display("FAIL %s idle whilo/stall got %b/%b exp 0/0", tag, bus.whilo_o, bus.stallreq_o);
        end
        checks++; if (bus.lo_o !== last_lo || bus.hi_o !== last_hi) begin
            errors++; $display("FAIL %s hold hilo got %h/%h exp %h/%h", tag, bus.hi_o, bus.lo_o, last_hi, last_lo);
        end
    endtask

    task automatic test_divu();
        run_div(c_op_divu, 32'd100, 32'd7, "divu_100_7");
        checks++; if (bus.lo_o !== 32'd14 || bus.hi_o !== 32'd2) begin
            errors++; $display("FAIL divu_const got %h/%h exp 2/14", bus.hi_o, bus.lo_o);
        end
        idle_check("divu_100_7");
        for (int i = 0; i < 5; i++) begin
            run_div(c_op_divu, $urandom, (i < 2) ? 32'($urandom_range(1, 255)) : $urandom | 32'h1, "divu_rand");
            idle_check("divu_rand");
        end
    endtask

    task automatic test_div_signed();
        run_div(c_op_div, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        checks++; if (bus.lo_o !== 32'hFFFF_FFFD || bus.hi_o !== 32'hFFFF_FFFF) begin
            errors++; $display("FAIL div_m7_2_const got %h/%h exp ffffffff/fffffffd", bus.hi_o, bus.lo_o);
        end
        idle_check("div_m7_2");
        run_div(c_op_div, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        checks++; if (bus.lo_o !== 32'h8000_0000 || bus.hi_o !== 32'h0) begin
            errors++; $display("FAIL div_ovf_const got %h/%h exp 0/80000000", bus.hi_o, bus.lo_o);
        end
        idle_check("div_ovf");
        for (int i = 0; i < 6; i++) begin
            run_div(c_op_div, $urandom, (i[0]) ? 32'(-$urandom_range(1, 1000)) : ($urandom | 32'h1), "div_rand");
            idle_check("div_rand");
        end
    endtask

    task automatic test_div_zero();
        run_div(c_op_div, 32'h1234_5678, 32'h0, "div_zero");
        checks++; if (bus.lo_o !== 32'hFFFF_FFFF || bus.hi_o !== 32'h1234_5678) begin
            errors++; $display("FAIL div_zero_const got %h/%h exp 12345678/ffffffff", bus.hi_o, bus.lo_o);
        end
        idle_check("div_zero");
        run_div(c_op_divu, $urandom, 32'h0, "divu_zero");
        idle_check("divu_zero");
    endtask

    task automatic test_back_to_back();
        run_div(c_op_divu, $urandom, 32'($urandom_range(1, 65535)), "b2b_first");
        run_div(c_op_div, $urandom, $urandom | 32'h1, "b2b_second");
        run_div(c_op_div, $urandom, 32'h0, "b2b_third");
        idle_check("b2b");
    endtask

    task automatic test_rst_busy();
        bit whilo_seen = 0;
        @(posedge clk); #1;
        drive(c_op_divu, c_sel_arith, 32'hDEAD_BEEF, 32'd13, 5'd7, 1'b1);
        repeat (11) begin
            @(posedge clk);
            @(negedge clk);
            if (bus.whilo_o !== 1'b0) whilo_seen = 1;
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.stallreq_o !== 1'b0) begin errors++; $display("FAIL rst_busy stall got %b exp 0", bus.stallreq_o); end
        checks++; if (bus.hi_o !== 32'h0 || bus.lo_o !== 32'h0) begin
            errors++; $display("FAIL rst_busy hilo got %h/%h exp 0/0", bus.hi_o, bus.lo_o);
        end
        @(negedge clk);
        if (bus.whilo_o !== 1'b0) whilo_seen = 1;
        @(posedge clk); #1;
        rst = 1'b0;
        drive(c_op_other, c_sel_nop, 32'h0, 32'h0, 5'h0, 1'b0);
        repeat (40) begin
            @(negedge clk);
            if (bus.whilo_o !== 1'b0) whilo_seen = 1;
        end
        checks++; if (whilo_seen) begin errors++; $display("FAIL rst_busy whilo got 1 exp 0"); end
        run_div(c_op_divu, 32'd9, 32'd3, "rst_fresh");
        checks++; if (bus.lo_o !== 32'd3 || bus.hi_o !== 32'd0) begin
            errors++; $display("FAIL rst_fresh_const got %h/%h exp 0/3", bus.hi_o, bus.lo_o);
        end
        idle_check("rst_fresh");
    endtask

    initial begin
        test_reset();
        test_logic();
        test_divu();
        test_div_signed();
        test_div_zero();
        test_back_to_back();
        test_rst_busy();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
